// File: rtl/switch_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : switch_pkg
//  Description : Shared constants for the three-way switch conditioning path
//                (channel count, A/B/C bit positions, default timing).
//  Revision    : 1.0  initial release
// ============================================================================
package switch_pkg;

  // Number of wall-switch channels feeding the light-parity block
  localparam int NUM_SW = 3;

  // Bit positions of each switch inside the 3-bit vectors
  localparam int SW_A = 2;
  localparam int SW_B = 1;
  localparam int SW_C = 0;

  // Default timing: accept a new level after this many mismatching edges
  localparam int DEF_DEBOUNCE_CYCLES = 16;
  // Default synchroniser depth
  localparam int DEF_SYNC_STAGES     = 2;

  // Counter width able to hold 0 .. debounce_cycles-1 (at least one bit)
  function automatic int cnt_width(input int debounce_cycles);
    return (debounce_cycles > 1) ? $clog2(debounce_cycles) : 1;
  endfunction

endpackage : switch_pkg
`default_nettype wire

// File: rtl/debounce_ch.sv
`default_nettype none
// ============================================================================
//  Module      : debounce_ch
//  Description : One switch channel: multi-flop synchroniser, mismatch
//                counter, registered clean level and one-cycle toggle pulse.
//  Revision    : 1.0  initial release
// ============================================================================
module debounce_ch
  import switch_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
  parameter int SYNC_STAGES     = DEF_SYNC_STAGES
) (
  input  logic clk,
  input  logic rst_n,
  input  logic raw,
  output logic clean,
  output logic toggle,
  output logic busy
);

  localparam int              CNT_W   = cnt_width(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

  // Illegal parameter values stop elaboration outright
  generate
    if (DEBOUNCE_CYCLES < 2) begin : g_bad_debounce
      $error("debounce_ch: DEBOUNCE_CYCLES must be >= 2");
    end
    if (SYNC_STAGES < 2) begin : g_bad_sync
      $error("debounce_ch: SYNC_STAGES must be >= 2");
    end
  endgenerate

  logic [SYNC_STAGES-1:0] r_sync;
  logic                   w_s;
  logic [CNT_W-1:0]       r_cnt;
  logic [CNT_W-1:0]       w_cnt_nxt;
  logic                   r_clean;
  logic                   w_clean_nxt;
  logic                   w_toggle_nxt;
  logic                   r_toggle;

  // Synchroniser shift chain; the oldest stage is the in-domain level
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync <= '0;
    end else begin
      r_sync <= {r_sync[SYNC_STAGES-2:0], raw};
    end
  end

  assign w_s = r_sync[SYNC_STAGES-1];

  // Next-state: any matching cycle clears the count; a full run of
  // mismatches commits the new level and raises the toggle for one edge.
  // The count is cleared on commit, so it never passes CNT_MAX.
  always_comb begin
    w_cnt_nxt    = '0;
    w_clean_nxt  = r_clean;
    w_toggle_nxt = 1'b0;
    if (w_s != r_clean) begin
      if (r_cnt == CNT_MAX) begin
        w_clean_nxt  = w_s;
        w_toggle_nxt = 1'b1;
      end else begin
        w_cnt_nxt = r_cnt + 1'b1;
      end
    end
  end

  // Counter, clean level and toggle registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt    <= '0;
      r_clean  <= 1'b0;
      r_toggle <= 1'b0;
    end else begin
      r_cnt    <= w_cnt_nxt;
      r_clean  <= w_clean_nxt;
      r_toggle <= w_toggle_nxt;
    end
  end

  assign clean  = r_clean;
  assign toggle = r_toggle;
  assign busy   = (r_cnt != '0);

endmodule : debounce_ch
`default_nettype wire

// File: rtl/switch_debounce3.sv
`default_nettype none
// ============================================================================
//  Module      : switch_debounce3
//  Description : Conditions the three raw wall-switch inputs {A,B,C} into
//                clean levels for the light-parity block, with per-channel
//                toggle pulses and a combined activity flag.
//  Revision    : 1.0  initial release
// ============================================================================
module switch_debounce3
  import switch_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
  parameter int SYNC_STAGES     = DEF_SYNC_STAGES
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [NUM_SW-1:0] sw_raw,
  output logic [NUM_SW-1:0] sw_clean,
  output logic [NUM_SW-1:0] toggle,
  output logic              any_toggle,
  output logic              busy
);

  logic [NUM_SW-1:0] w_ch_busy;

  // One independent debounce channel per switch; bit i of every vector
  // belongs to channel i (A = bit 2, B = bit 1, C = bit 0)
  generate
    for (genvar i = 0; i < NUM_SW; i++) begin : g_ch
      debounce_ch #(
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
        .SYNC_STAGES     (SYNC_STAGES)
      ) u_ch (
        .clk    (clk),
        .rst_n  (rst_n),
        .raw    (sw_raw[i]),
        .clean  (sw_clean[i]),
        .toggle (toggle[i]),
        .busy   (w_ch_busy[i])
      );
    end
  endgenerate

  // Both flags are plain ORs of registered per-channel state
  assign any_toggle = |toggle;
  assign busy       = |w_ch_busy;

endmodule : switch_debounce3
`default_nettype wire

// File: tb/tb_switch_debounce3.sv
`default_nettype none
// ============================================================================
//  Module      : tb_switch_debounce3
//  Description : Self-checking bench for switch_debounce3 (DEBOUNCE_CYCLES=4,
//                SYNC_STAGES=2). Expected outputs are queued per edge when
//                stimulus is applied and popped as each edge is sampled.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_switch_debounce3;

  localparam int DEB  = 4;
  localparam int SYN  = 2;
  localparam int LAT  = SYN + DEB;   // edge on which sw_clean/toggle update

  typedef struct {
    logic [2:0] clean;
    logic [2:0] tog;
    logic       any;
    logic       busy;
  } exp_t;

  logic       clk;
  logic       rst_n;
  logic [2:0] sw_raw;
  logic [2:0] sw_clean;
  logic [2:0] toggle;
  logic       any_toggle;
  logic       busy;

  int   n_checks = 0;
  int   n_fail   = 0;
  exp_t sb[$];

  switch_debounce3 #(
    .DEBOUNCE_CYCLES (DEB),
    .SYNC_STAGES     (SYN)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .sw_raw     (sw_raw),
    .sw_clean   (sw_clean),
    .toggle     (toggle),
    .any_toggle (any_toggle),
    .busy       (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Expected outputs on edge k after a steady raw change from oldv to newv
  function automatic exp_t steady_exp(input logic [2:0] oldv,
                                      input logic [2:0] newv, input int k);
    exp_t e;
    logic [2:0] m;
    m      = oldv ^ newv;
    e.clean = (k >= LAT) ? newv : oldv;
    e.tog   = (k == LAT) ? m : 3'b000;
    e.any   = (k == LAT) && (m != 3'b000);
    e.busy  = (m != 3'b000) && (k >= SYN + 1) && (k < LAT);
    return e;
  endfunction

  task automatic do_reset(input logic [2:0] v);
    @(negedge clk);
    rst_n  = 1'b0;
    sw_raw = v;
    @(negedge clk);
    @(negedge clk);
    rst_n  = 1'b1;
    repeat (3) @(negedge clk);
  endtask

  // ---------------------------------------------------------------- test 1
  task automatic test_reset;
    exp_t e;
    rst_n  = 1'b0;
    sw_raw = 3'b111;
    repeat (3) @(negedge clk);
    n_checks += 4;
    if (sw_clean !== 3'b000) begin n_fail++; $display("FAIL reset_clean: got %b expected 000", sw_clean); end
    if (toggle !== 3'b000) begin n_fail++; $display("FAIL reset_toggle: got %b expected 000", toggle); end
    if (any_toggle !== 1'b0) begin n_fail++; $display("FAIL reset_any: got %b expected 0", any_toggle); end
    if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b expected 0", busy); end
    rst_n = 1'b1;
    for (int k = 1; k <= LAT + 2; k++) sb.push_back(steady_exp(3'b000, 3'b111, k));
    for (int k = 1; k <= LAT + 2; k++) begin
      @(posedge clk); #1;
      e = sb.pop_front();
      n_checks += 4;
      if (sw_clean !== e.clean) begin n_fail++; $display("FAIL rel_clean edge %0d: got %b expected %b", k, sw_clean, e.clean); end
      if (toggle !== e.tog) begin n_fail++; $display("FAIL rel_toggle edge %0d: got %b expected %b", k, toggle, e.tog); end
      if (any_toggle !== e.any) begin n_fail++; $display("FAIL rel_any edge %0d: got %b expected %b", k, any_toggle, e.any); end
      if (busy !== e.busy) begin n_fail++; $display("FAIL rel_busy edge %0d: got %b expected %b", k, busy, e.busy); end
    end
  endtask

  // ---------------------------------------------------------------- test 2
  task automatic test_glitch;
    exp_t e;
    do_reset(3'b000);
    // three raw-high cycles give three mismatch edges (3,4,5): never accepted
    for (int k = 1; k <= 10; k++) begin
      e.clean = 3'b000; e.tog = 3'b000; e.any = 1'b0;
      e.busy  = (k >= 3) && (k <= 5);
      sb.push_back(e);
    end
    @(negedge clk);
    sw_raw = 3'b010;
    for (int k = 1; k <= 10; k++) begin
      @(posedge clk); #1;
      if (k == 3) sw_raw = 3'b000;
      e = sb.pop_front();
      n_checks += 4;
      if (sw_clean !== e.clean) begin n_fail++; $display("FAIL glitch_clean edge %0d: got %b expected %b", k, sw_clean, e.clean); end
      if (toggle !== e.tog) begin n_fail++; $display("FAIL glitch_toggle edge %0d: got %b expected %b", k, toggle, e.tog); end
      if (any_toggle !== e.any) begin n_fail++; $display("FAIL glitch_any edge %0d: got %b expected %b", k, any_toggle, e.any); end
      if (busy !== e.busy) begin n_fail++; $display("FAIL glitch_busy edge %0d: got %b expected %b", k, busy, e.busy); end
    end
  endtask

  // ---------------------------------------------------------------- test 3
  task automatic test_press;
    exp_t e;
    do_reset(3'b000);
    for (int k = 1; k <= LAT + 4; k++) sb.push_back(steady_exp(3'b000, 3'b100, k));
    @(negedge clk);
    sw_raw = 3'b100;
    for (int k = 1; k <= LAT + 4; k++) begin
      @(posedge clk); #1;
      e = sb.pop_front();
      n_checks += 4;
      if (sw_clean !== e.clean) begin n_fail++; $display("FAIL press_clean edge %0d: got %b expected %b", k, sw_clean, e.clean); end
      if (toggle !== e.tog) begin n_fail++; $display("FAIL press_toggle edge %0d: got %b expected %b", k, toggle, e.tog); end
      if (any_toggle !== e.any) begin n_fail++; $display("FAIL press_any edge %0d: got %b expected %b", k, any_toggle, e.any); end
      if (busy !== e.busy) begin n_fail++; $display("FAIL press_busy edge %0d: got %b expected %b", k, busy, e.busy); end
    end
  endtask

  // ---------------------------------------------------------------- test 4
  task automatic test_bounce;
    exp_t e;
    logic seq [0:11];
    int   pulses;
    // raw[0] as sampled on edges 1..12: 1,1,0,1,1,...; final rise sampled at edge 4
    for (int k = 0; k < 12; k++) seq[k] = (k == 2) ? 1'b0 : 1'b1;
    do_reset(3'b000);
    for (int k = 1; k <= 12; k++) begin
      e.clean = (k >= 4 + 5) ? 3'b001 : 3'b000;
      e.tog   = (k == 4 + 5) ? 3'b001 : 3'b000;
      e.any   = (k == 4 + 5);
      e.busy  = (k == 3) || (k == 4) || (k >= 6 && k <= 8);
      sb.push_back(e);
    end
    pulses = 0;
    @(negedge clk);
    sw_raw = {2'b00, seq[0]};
    for (int k = 1; k <= 12; k++) begin
      @(posedge clk); #1;
      if (k < 12) sw_raw = {2'b00, seq[k]};
      if (toggle[0] === 1'b1) pulses++;
      e = sb.pop_front();
      n_checks += 4;
      if (sw_clean !== e.clean) begin n_fail++; $display("FAIL bounce_clean edge %0d: got %b expected %b", k, sw_clean, e.clean); end
      if (toggle !== e.tog) begin n_fail++; $display("FAIL bounce_toggle edge %0d: got %b expected %b", k, toggle, e.tog); end
      if (any_toggle !== e.any) begin n_fail++; $display("FAIL bounce_any edge %0d: got %b expected %b", k, any_toggle, e.any); end
      if (busy !== e.busy) begin n_fail++; $display("FAIL bounce_busy edge %0d: got %b expected %b", k, busy, e.busy); end
    end
    n_checks++;
    if (pulses != 1) begin n_fail++; $display("FAIL bounce_pulses: got %0d expected 1", pulses); end
  endtask

  // ---------------------------------------------------------------- test 5
  task automatic test_simultaneous;
    exp_t e;
    do_reset(3'b000);
    for (int k = 1; k <= LAT + 2; k++) sb.push_back(steady_exp(3'b000, 3'b011, k));
    @(negedge clk);
    sw_raw = 3'b011;
    for (int k = 1; k <= LAT + 2; k++) begin
      @(posedge clk); #1;
      e = sb.pop_front();
      n_checks += 4;
      if (sw_clean !== e.clean) begin n_fail++; $display("FAIL simul_on_clean edge %0d: got %b expected %b", k, sw_clean, e.clean); end
      if (toggle !== e.tog) begin n_fail++; $display("FAIL simul_on_toggle edge %0d: got %b expected %b", k, toggle, e.tog); end
      if (any_toggle !== e.any) begin n_fail++; $display("FAIL simul_on_any edge %0d: got %b expected %b", k, any_toggle, e.any); end
      if (busy !== e.busy) begin n_fail++; $display("FAIL simul_on_busy edge %0d: got %b expected %b", k, busy, e.busy); end
    end
    for (int k = 1; k <= LAT + 2; k++) sb.push_back(steady_exp(3'b011, 3'b000, k));
    @(negedge clk);
    sw_raw = 3'b000;
    for (int k = 1; k <= LAT + 2; k++) begin
      @(posedge clk); #1;
      e = sb.pop_front();
      n_checks += 4;
      if (sw_clean !== e.clean) begin n_fail++; $display("FAIL simul_off_clean edge %0d: got %b expected %b", k, sw_clean, e.clean); end
      if (toggle !== e.tog) begin n_fail++; $display("FAIL simul_off_toggle edge %0d: got %b expected %b", k, toggle, e.tog); end
      if (any_toggle !== e.any) begin n_fail++; $display("FAIL simul_off_any edge %0d: got %b expected %b", k, any_toggle, e.any); end
      if (busy !== e.busy) begin n_fail++; $display("FAIL simul_off_busy edge %0d: got %b expected %b", k, busy, e.busy); end
    end
  endtask

  // ---------------------------------------------------------------- test 6
  task automatic test_reset_mid_count;
    exp_t e;
    do_reset(3'b000);
    // count reaches 2 after edge 4; reset lands before that channel commits
    for (int k = 1; k <= 4; k++) sb.push_back(steady_exp(3'b000, 3'b100, k));
    @(negedge clk);
    sw_raw = 3'b100;
    for (int k = 1; k <= 4; k++) begin
      @(posedge clk); #1;
      e = sb.pop_front();
      n_checks += 2;
      if (sw_clean !== e.clean) begin n_fail++; $display("FAIL mid_clean edge %0d: got %b expected %b", k, sw_clean, e.clean); end
      if (busy !== e.busy) begin n_fail++; $display("FAIL mid_busy edge %0d: got %b expected %b", k, busy, e.busy); end
    end
    #2;
    rst_n = 1'b0;
    #1;
    n_checks += 3;
    if (sw_clean !== 3'b000) begin n_fail++; $display("FAIL midrst_clean: got %b expected 000", sw_clean); end
    if (busy !== 1'b0) begin n_fail++; $display("FAIL midrst_busy: got %b expected 0", busy); end
    if (toggle !== 3'b000) begin n_fail++; $display("FAIL midrst_toggle: got %b expected 000", toggle); end
    @(negedge clk);
    @(negedge clk);
    n_checks += 2;
    if (toggle !== 3'b000) begin n_fail++; $display("FAIL midrst_hold_toggle: got %b expected 000", toggle); end
    if (busy !== 1'b0) begin n_fail++; $display("FAIL midrst_hold_busy: got %b expected 0", busy); end
    rst_n = 1'b1;
    for (int k = 1; k <= LAT + 2; k++) sb.push_back(steady_exp(3'b000, 3'b100, k));
    for (int k = 1; k <= LAT + 2; k++) begin
      @(posedge clk); #1;
      e = sb.pop_front();
      n_checks += 4;
      if (sw_clean !== e.clean) begin n_fail++; $display("FAIL after_clean edge %0d: got %b expected %b", k, sw_clean, e.clean); end
      if (toggle !== e.tog) begin n_fail++; $display("FAIL after_toggle edge %0d: got %b expected %b", k, toggle, e.tog); end
      if (any_toggle !== e.any) begin n_fail++; $display("FAIL after_any edge %0d: got %b expected %b", k, any_toggle, e.any); end
      if (busy !== e.busy) begin n_fail++; $display("FAIL after_busy edge %0d: got %b expected %b", k, busy, e.busy); end
    end
  endtask

  initial begin
    rst_n  = 1'b0;
    sw_raw = 3'b000;
    test_reset();
    test_glitch();
    test_press();
    test_bounce();
    test_simultaneous();
    test_reset_mid_count();
    n_checks++;
    if (sb.size() != 0) begin n_fail++; $display("FAIL scoreboard_drain: got %0d entries expected 0", sb.size()); end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule : tb_switch_debounce3
`default_nettype wire

// File: doc/switch_debounce3.md
Name: switch_debounce3

Overview:
- Upstream conditioning stage for the three-way light logic.
- Takes three raw, asynchronous, bouncy wall-switch inputs.
- Synchronises each input into the clock domain and debounces it with a per-channel counter.
- Drives clean, stable levels {A,B,C} to the light-parity block. Also emits one-cycle toggle pulses for event logging.

Parameters:
- DEBOUNCE_CYCLES, 16: consecutive mismatching cycles required to accept a new level. Legal range is ≥2; elaboration fails otherwise.
- SYNC_STAGES, 2: synchroniser flop depth. Legal range is ≥2.
- CNT_W, $clog2(DEBOUNCE_CYCLES): counter width. Derived; do not override.

Ports:
- clk  input  1  single system clock, rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- sw_raw  input  3  raw switch levels: bit2 = A, bit1 = B, bit0 = C. Asynchronous to clk.
- sw_clean  output  3  debounced levels, same bit mapping; feeds {A,B,C} of the light-parity block.
- toggle  output  3  per-channel one-cycle pulse, high in the cycle sw_clean changes.
- any_toggle  output  1  OR of toggle.
- busy  output  1  high while any channel counter is non-zero.

Behaviour:
- Reset and interface: one clock, clk. Reset is rst_n, asynchronous, active-low.
- Reset values: while rst_n=0, all synchroniser flops, counters, sw_clean, toggle, any_toggle and busy are 0, immediately and regardless of clk.
- Channels are independent and identical; the three channels share no state.
- Synchroniser: sw_raw[i] passes through SYNC_STAGES flops; the last stage output is s[i].
- Counter, at each rising edge:
  - s[i] == sw_clean[i]: cnt[i] <= 0 (glitch/bounce rejected).
  - s[i] != sw_clean[i] and cnt[i] < DEBOUNCE_CYCLES-1: cnt[i] <= cnt[i]+1.
  - s[i] != sw_clean[i] and cnt[i] == DEBOUNCE_CYCLES-1: sw_clean[i] <= s[i], cnt[i] <= 0, toggle[i] <= 1.
- Pulse width: toggle[i] is 0 on every other edge, so it is high for exactly one cycle per accepted change.
- Latency: take the first edge that samples a new steady raw level as edge 1. sw_clean updates on edge SYNC_STAGES+DEBOUNCE_CYCLES; toggle rises on the same edge. With defaults this is edge 18.
- Bounce: any cycle where s matches sw_clean restarts the count. An accepted change always needs DEBOUNCE_CYCLES uninterrupted mismatch edges.
- Minimum pulse: a raw pulse that yields fewer than DEBOUNCE_CYCLES mismatch edges at s never reaches sw_clean.
- Counter bound: the counter never exceeds DEBOUNCE_CYCLES-1; no wrap is possible.
- Simultaneous events: several toggle bits may assert in the same cycle. any_toggle is registered-equivalent, i.e. it coincides with toggle.
- busy is combinational OR of (cnt[i] != 0) across channels.
- Reset mid-count: all progress is discarded with no toggle. After release, sw_clean starts at 0. A raw level held at 1 is accepted after the full latency and reported as a 0→1 toggle.
- All outputs are glitch-free registered values except busy and any_toggle (OR of registers).

Decomposition:
- Package switch_pkg:
  - NUM_SW = 3.
  - SW_A = 2, SW_B = 1, SW_C = 0 bit indices.
  - Default DEBOUNCE_CYCLES and SYNC_STAGES constants.
- Sub-module debounce_ch: one channel (synchroniser, counter, clean flop, toggle flop), with parameters DEBOUNCE_CYCLES and SYNC_STAGES. Instantiated NUM_SW times via generate.
- Top level: instantiates the channels plus the two OR reductions.

Test Plan (bench overrides DEBOUNCE_CYCLES=4, SYNC_STAGES=2; edge 1 = first sampling edge):
1. Reset release: rst_n=0 with sw_raw=111, then release and hold.
   - During reset: all outputs 0.
   - Edge 6 after release: sw_clean=111, toggle=111 for one cycle, busy falls to 0 at the same edge.
2. Glitch rejection: sw_raw[1] pulses 0→1 for 3 cycles then returns to 0.
   - busy high for up to 3 cycles.
   - sw_clean and toggle stay 000 throughout.
3. Clean press: sw_raw = 000 → 100, held.
   - Edge 6: sw_clean=100, toggle=100, any_toggle=1 for exactly one cycle.
   - Thereafter toggle=000.
4. Bounce: sw_raw[0] samples 1,1,0,1,1,1,1,…
   - sw_clean[0] rises 5 edges after the final 0→1 sampling edge, i.e. on that edge's index + 5.
   - Exactly one toggle[0] pulse.
5. Simultaneous change: sw_raw = 000 → 011 on the same cycle.
   - Edge 6: sw_clean=011, toggle=011 in a single cycle.
   - Then release to 000: toggle=011 again, 6 edges later.
6. Reset mid-count: sw_raw[2] → 1, assert rst_n=0 when cnt[2]=2.
   - Immediately: sw_clean=000, busy=0, no toggle.
   - After release with sw_raw[2] still 1: sw_clean[2]=1 on edge 6 after release.
